// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin arbiter sharing one FIFO enqueue port among M producers.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to BURST consecutive words.

module fifo_enq_arb_lane #(
    parameter int N = 4
) (
    input  logic         gnt,
    input  logic [N-1:0] data,
    output logic [N-1:0] word
);
    assign word = gnt ? data : '0;
endmodule

module fifo_enq_arbiter #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int BURST = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [M-1:0]         req,
    input  logic [M*N-1:0]       req_data,
    output logic [M-1:0]         gnt,
    input  logic                 full,
    output logic                 we,
    output logic [N-1:0]         wdata,
    output logic                 busy,
    output logic [$clog2(M)-1:0] owner
);
    localparam int PW = $clog2(M);

`ifdef FIFO_ARB_BURST_EN
    localparam bit HOLD_EN = (BURST > 1);
`else
    localparam bit HOLD_EN = 1'b0 && (BURST > 1);
`endif

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         own;
    logic                  hold_mode;
    logic                  hold_req;
    logic [PW-1:0]         start;
    logic                  found;
    logic [PW-1:0]         win;
    logic [M-1:0][N-1:0]   lane_word;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return PW'((int'(i) + 1) % M);
    endfunction

    assign hold_req = hold_mode && req[own];
    assign start    = hold_mode ? nxt(own) : ptr;

    // First requester at or after start, wrapping modulo M (M need not be a power of two).
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < M; k++) begin
            if (!found && req[(int'(start) + k) % M]) begin
                found = 1'b1;
                win   = PW'((int'(start) + k) % M);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (rst_n && !full) begin
            if (hold_req)
                gnt[own] = 1'b1;
            else if (found)
                gnt[win] = 1'b1;
        end
    end

    assign we = |gnt;

    for (genvar i = 0; i < M; i++) begin : g_lane
        fifo_enq_arb_lane #(.N(N)) u_lane (
            .gnt  (gnt[i]),
            .data (req_data[i*N +: N]),
            .word (lane_word[i])
        );
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < M; i++)
            wdata = wdata | lane_word[i];
    end

    assign owner = own;

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, HOLD} st_t;

    st_t           st;
    logic [CW-1:0] cnt;

    assign hold_mode = (st == HOLD);
    assign busy      = (st == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= IDLE;
            ptr <= '0;
            own <= '0;
            cnt <= '0;
        end else if (hold_req) begin
            // Owner still requesting: a full FIFO freezes the burst in place.
            if (!full) begin
                if (int'(cnt) + 1 == BURST) begin
                    st  <= IDLE;
                    ptr <= nxt(own);
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else if (found) begin
            if (!full) begin
                own <= win;
                if (HOLD_EN) begin
                    st  <= HOLD;
                    cnt <= CW'(1);
                end else begin
                    st  <= IDLE;
                    ptr <= nxt(win);
                end
            end
        end else if (st == HOLD) begin
            st  <= IDLE;
            ptr <= nxt(own);
            cnt <= '0;
        end
    end
`else
    assign hold_mode = 1'b0;
    assign busy      = HOLD_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            own <= '0;
        end else if (found && !full) begin
            ptr <= nxt(win);
            own <= win;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: hand-computed vector table, mid-burst reset, then random traffic
// checked against a round-robin reference model. Works with or without FIFO_ARB_BURST_EN.
module tb_fifo_enq_arbiter;
    localparam int N     = 4;
    localparam int M     = 4;
    localparam int BURST = 2;
    localparam int PW    = 2;

`ifdef FIFO_ARB_BURST_EN
    localparam bit BM = (BURST > 1);
`else
    localparam bit BM = 1'b0;
`endif

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic [M-1:0]   req      = '0;
    logic [M*N-1:0] req_data = '0;
    logic           full     = 1'b0;
    logic [M-1:0]   gnt;
    logic           we;
    logic [N-1:0]   wdata;
    logic           busy;
    logic [PW-1:0]  owner;

    fifo_enq_arbiter #(.N(N), .M(M), .BURST(BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .full     (full),
        .we       (we),
        .wdata    (wdata),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: next priority index, current owner, burst words taken, in-burst flag
    int m_ptr  = 0;
    int m_own  = 0;
    int m_cnt  = 0;
    bit m_hold = 1'b0;

    typedef struct {
        logic [M-1:0]  req;
        logic          full;
        logic [M-1:0]  gnt;
        logic [N-1:0]  wd;
        logic          busy;
        logic [PW-1:0] owner;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_own  = 0;
        m_cnt  = 0;
        m_hold = 1'b0;
    endtask

    // Compare the current cycle against the model, then advance the model to the coming edge.
    task automatic model_check();
        int           cand;
        int           s;
        logic [M-1:0] eg;
        logic [N-1:0] ew;
        cand = -1;
        if (m_hold && req[m_own]) begin
            cand = m_own;
        end else begin
            s = m_hold ? (m_own + 1) % M : m_ptr;
            for (int k = 0; k < M; k++)
                if (cand < 0 && req[(s + k) % M]) cand = (s + k) % M;
        end
        eg = '0;
        ew = '0;
        if (!full && cand >= 0) begin
            eg[cand] = 1'b1;
            ew = req_data[cand*N +: N];
        end
        chk("model_gnt", 32'(gnt), 32'(eg));
        chk("model_we", 32'(we), 32'(|eg));
        chk("model_wdata", 32'(wdata), 32'(ew));
        chk("model_busy", 32'(busy), 32'(m_hold));
        chk("model_owner", 32'(owner), 32'(m_own));
        if (m_hold && req[m_own]) begin
            if (!full) begin
                m_cnt++;
                if (m_cnt == BURST) begin
                    m_hold = 1'b0;
                    m_ptr  = (m_own + 1) % M;
                    m_cnt  = 0;
                end
            end
        end else if (cand >= 0) begin
            if (!full) begin
                m_own = cand;
                if (BM) begin
                    m_hold = 1'b1;
                    m_cnt  = 1;
                end else begin
                    m_ptr = (cand + 1) % M;
                end
            end
        end else if (m_hold) begin
            m_hold = 1'b0;
            m_ptr  = (m_own + 1) % M;
            m_cnt  = 0;
        end
    endtask

    initial begin
        // word of requester i: 0:A 1:B 2:C 3:D
        req_data = 16'hDCBA;
`ifdef FIFO_ARB_BURST_EN
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 4'hA, 1'b0, 2'd0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 4'hA, 1'b1, 2'd0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0010, 4'hB, 1'b0, 2'd0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 4'h0, 1'b1, 2'd1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 4'h0, 1'b1, 2'd1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 4'h0, 1'b1, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 4'b0010, 4'hB, 1'b1, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 4'b0100, 4'hC, 1'b0, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 4'b0100, 4'hC, 1'b1, 2'd2});
        tbl.push_back('{4'b1111, 1'b0, 4'b1000, 4'hD, 1'b0, 2'd2});
        tbl.push_back('{4'b1111, 1'b0, 4'b1000, 4'hD, 1'b1, 2'd3});
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 4'hA, 1'b0, 2'd3});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 4'hC, 1'b1, 2'd0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 4'hC, 1'b1, 2'd2});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0, 2'd2});
        tbl.push_back('{4'b0010, 1'b0, 4'b0010, 4'hB, 1'b0, 2'd2});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 4'h0, 1'b1, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 4'b0100, 4'hC, 1'b0, 2'd1});
`else
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 4'hA, 1'b0, 2'd0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0010, 4'hB, 1'b0, 2'd0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0100, 4'hC, 1'b0, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 4'b1000, 4'hD, 1'b0, 2'd2});
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 4'hA, 1'b0, 2'd3});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 4'h0, 1'b0, 2'd0});
        tbl.push_back('{4'b1001, 1'b0, 4'b1000, 4'hD, 1'b0, 2'd0});
        tbl.push_back('{4'b1001, 1'b0, 4'b0001, 4'hA, 1'b0, 2'd3});
        tbl.push_back('{4'b1001, 1'b0, 4'b1000, 4'hD, 1'b0, 2'd0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 4'h0, 1'b0, 2'd3});
        tbl.push_back('{4'b0110, 1'b0, 4'b0010, 4'hB, 1'b0, 2'd3});
        tbl.push_back('{4'b0110, 1'b0, 4'b0100, 4'hC, 1'b0, 2'd1});
        tbl.push_back('{4'b0010, 1'b0, 4'b0010, 4'hB, 1'b0, 2'd2});
`endif

        // reset with every requester asserted: nothing may reach the FIFO
        rst_n = 1'b0;
        req   = 4'b1111;
        full  = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        model_reset();

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = 1'b1;
            req   = tbl[i].req;
            full  = tbl[i].full;
            #2;
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_we", i), 32'(we), 32'(|tbl[i].gnt));
            chk($sformatf("tbl%0d_wdata", i), 32'(wdata), 32'(tbl[i].wd));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
            model_check();
        end

        // owner stalled by full, then asynchronous reset lands mid-burst
        @(negedge clk);
        req  = 4'b0100;
        full = 1'b1;
        #2;
        model_check();
        @(negedge clk);
        #2;
        model_check();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_we", 32'(we), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_owner", 32'(owner), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        full  = 1'b0;
        #2;
        chk("postrst_gnt", 32'(gnt), 32'h1);
        chk("postrst_wdata", 32'(wdata), 32'hA);
        model_check();

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req      = M'($urandom_range(0, (1 << M) - 1));
            full     = ($urandom_range(0, 3) == 0);
            req_data = (M*N)'($urandom);
            #2;
            model_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
